// File: rtl/guitar_scorer.sv
// Note-judging and scoring engine: synchronises the strum, judges frets against the notes at the
// hit line, keeps a saturating score/combo/multiplier and posts each judgement on a valid/ready port.
module guitar_scorer #(
    parameter int LANES        = 4,
    parameter int SCORE_W      = 32,
    parameter int COMBO_W      = 8,
    parameter int BASE_POINTS  = 1,
    parameter int COMBO_STEP   = 10,
    parameter int MULT_MAX     = 4,
    parameter int MISS_PENALTY = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               strum,
    input  logic [LANES-1:0]   buttons,
    input  logic [LANES-1:0]   intersections,
    input  logic [LANES-1:0]   note_pass,
    input  logic               clear_score,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [2:0]         mult,
    output logic               evt_valid,
    output logic               evt_hit,
    input  logic               evt_ready,
    output logic               evt_overflow,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, EVAL, APPLY} state_t;

    localparam logic [SCORE_W:0]   SCORE_CAP = {1'b0, {SCORE_W{1'b1}}};
    localparam logic [SCORE_W:0]   BASE_EXT  = (SCORE_W+1)'(BASE_POINTS);
    localparam logic [SCORE_W-1:0] PENALTY   = SCORE_W'(MISS_PENALTY);
    localparam logic [COMBO_W:0]   STEP_EXT  = (COMBO_W+1)'(COMBO_STEP);
    localparam logic [COMBO_W:0]   MULT_CAP  = (COMBO_W+1)'(MULT_MAX);

    state_t           state;
    logic             strum_meta, strum_sync, strum_prev;
    logic [LANES-1:0] btn_lat, isect_lat, hit_flags;
    logic             from_strum, judged_hit, pend_miss;

    logic             strum_edge, eval_hit, pass_miss, pend_take;
    logic [LANES-1:0] set_flags;

    assign strum_edge = strum_sync & ~strum_prev;
    // A pending-miss pass has from_strum=0, so it is always judged a miss
    assign eval_hit   = from_strum && (isect_lat != '0) && (btn_lat == isect_lat);
    assign set_flags  = (state == EVAL && eval_hit) ? isect_lat : '0;
    // A lane being marked hit this cycle does not count as passing unhit
    assign pass_miss  = |(note_pass & ~hit_flags & ~set_flags);
    assign pend_take  = (state == IDLE) && !strum_edge && pend_miss;

    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_hit, score_miss;
    logic [COMBO_W-1:0] combo_hit;
    logic [COMBO_W:0]   mult_raw;
    logic [2:0]         mult_hit;

    always_comb begin
        score_sum  = {1'b0, score} + BASE_EXT * (SCORE_W+1)'(mult);
        score_hit  = (score_sum > SCORE_CAP) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
        score_miss = (score > PENALTY) ? score - PENALTY : '0;
        combo_hit  = (combo == {COMBO_W{1'b1}}) ? combo : combo + COMBO_W'(1);
        mult_raw   = {1'b0, combo_hit} / STEP_EXT + (COMBO_W+1)'(1);
        mult_hit   = (mult_raw >= MULT_CAP) ? 3'(MULT_MAX) : mult_raw[2:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            strum_meta   <= 1'b0;
            strum_sync   <= 1'b0;
            strum_prev   <= 1'b0;
            btn_lat      <= '0;
            isect_lat    <= '0;
            hit_flags    <= '0;
            from_strum   <= 1'b0;
            judged_hit   <= 1'b0;
            pend_miss    <= 1'b0;
            score        <= '0;
            combo        <= '0;
            mult         <= 3'd1;
            evt_valid    <= 1'b0;
            evt_hit      <= 1'b0;
            evt_overflow <= 1'b0;
            busy         <= 1'b0;
        end else begin
            strum_meta <= strum;
            strum_sync <= strum_meta;
            strum_prev <= strum_sync;
            hit_flags  <= (hit_flags & ~note_pass) | set_flags;

            if (pass_miss)
                pend_miss <= 1'b1;
            else if (pend_take)
                pend_miss <= 1'b0;

            if (evt_valid && evt_ready)
                evt_valid <= 1'b0;

            if (clear_score) begin
                score        <= '0;
                combo        <= '0;
                mult         <= 3'd1;
                evt_overflow <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (strum_edge) begin
                        btn_lat    <= buttons;
                        isect_lat  <= intersections;
                        from_strum <= 1'b1;
                        state      <= EVAL;
                        busy       <= 1'b1;
                    end else if (pend_miss) begin
                        from_strum <= 1'b0;
                        state      <= EVAL;
                        busy       <= 1'b1;
                    end
                end
                EVAL: begin
                    judged_hit <= eval_hit;
                    state      <= APPLY;
                end
                APPLY: begin
                    if (!clear_score) begin
                        if (judged_hit) begin
                            score <= score_hit;
                            combo <= combo_hit;
                            mult  <= mult_hit;
                        end else begin
                            score <= score_miss;
                            combo <= '0;
                            mult  <= 3'd1;
                        end
                    end
                    // A held, unaccepted event is never overwritten
                    if (!evt_valid || evt_ready) begin
                        evt_valid <= 1'b1;
                        evt_hit   <= judged_hit;
                    end else begin
                        evt_overflow <= 1'b1;
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
